serial_subtractor: RTL

//  Bit-serial two's-complement subtractor, the inverse datapath of the ripple adders.

---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, LSB first, WIDTH cycles/result.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output o_V.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_D,
  output logic             o_B,
  output logic             o_busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_V
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_a, bit_b, bit_d, br_next;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  assign bit_a   = op_a_q[0];
  assign bit_b   = op_b_q[0];
  assign bit_d   = bit_a ^ bit_b ^ br_q;
  assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d = StRun;
          op_a_d  = i_A;
          op_b_d  = i_B;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        op_a_d = op_a_q >> 1;
        op_b_d = op_b_q >> 1;
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // On the last cycle the cell sees the sign bits of A, B and D.
          ovf_d   = (bit_a ^ bit_b) & (bit_d ^ bit_a);
`endif
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = (state_q == StRun);
  assign o_valid = (state_q == StDone);
  assign o_D     = diff_q;
  assign o_B     = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign o_V     = ovf_q;
`endif

endmodule
